stream_mux_rr: RTL and testbench

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/stream_mux_rr.sv | 114 +++++++++++
 tb/tb_stream_mux_rr.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
// Shared constants for the round-robin stream multiplexer:
//   MODE_FIXED / MODE_RR : encodings of the top-level 'mode' input
//   BEAT_CNT_W           : width of the delivered-beat counter
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int BEAT_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin search: returns the first asserted request at or
// above 'ptr', wrapping from N_CH-1 back to 0.
// Ports:
//   req       [N_CH-1:0]  request vector
//   ptr       [SEL_W-1:0] starting channel of the search (always < N_CH)
//   gnt_valid             some request was found
//   gnt_idx   [SEL_W-1:0] index of the granted channel
module rr_arbiter #(
  parameter int N_CH = 8,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  localparam logic [SEL_W:0] N_CH_EXT = (SEL_W + 1)'(N_CH);

  // Rotate the request vector so that channel 'ptr' lands on bit 0; the
  // doubled vector makes the wrap-around free.
  logic [N_CH-1:0]  req_rot;
  logic [SEL_W-1:0] offset;
  logic [SEL_W:0]   sum;

  assign req_rot = N_CH'({req, req} >> ptr);

  always_comb begin
    gnt_valid = 1'b0;
    offset    = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!gnt_valid && req_rot[k]) begin
        gnt_valid = 1'b1;
        offset    = SEL_W'(k);
      end
    end
  end

  // Undo the rotation: (ptr + offset) mod N_CH, with one extra bit so the
  // sum cannot overflow before the modulo correction.
  assign sum     = {1'b0, ptr} + {1'b0, offset};
  assign gnt_idx = (sum >= N_CH_EXT) ? SEL_W'(sum - N_CH_EXT) : sum[SEL_W-1:0];

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// N_CH-to-1 stream multiplexer with a one-deep registered output.
// Channel choice is either a fixed select (mode=0) or round-robin (mode=1).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_data        per-channel beats, channel i at [i*DATA_W +: DATA_W]
//   in_ready                one-hot (or zero) accept strobe to the granted channel
//   sel, mode               fixed channel select, arbitration mode
//   out_valid/out_data/out_ch/out_ready  registered output beat and its source
//   beat_cnt                wrapping count of beats accepted downstream
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   mode,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready,
  output logic [BEAT_CNT_W-1:0]  beat_cnt
);

  localparam int SEL_SPAN = 1 << SEL_W;

  logic                  out_valid_reg;
  logic [DATA_W-1:0]     out_data_reg;
  logic [SEL_W-1:0]      out_ch_reg;
  logic [SEL_W-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [BEAT_CNT_W-1:0] beat_cnt_reg;

  logic                  rr_gnt_valid;
  logic [SEL_W-1:0]      rr_gnt_idx;
  logic [SEL_SPAN-1:0]   valid_ext;
  logic                  fix_gnt_valid;
  logic                  gnt_valid;
  logic [SEL_W-1:0]      gnt_idx;
  logic                  can_load;
  logic                  load;
  logic                  deliver;
  logic [DATA_W-1:0]     ch_data [N_CH];

  rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (rr_ptr_reg),
    .gnt_valid (rr_gnt_valid),
    .gnt_idx   (rr_gnt_idx)
  );

  // Zero-extending in_valid to the full select range makes any sel >= N_CH
  // read a 0, so an out-of-range select simply never grants.
  assign valid_ext     = SEL_SPAN'(in_valid);
  assign fix_gnt_valid = valid_ext[sel];

  assign gnt_valid = (mode == MODE_RR) ? rr_gnt_valid : fix_gnt_valid;
  assign gnt_idx   = (mode == MODE_RR) ? rr_gnt_idx   : sel;

  assign can_load = !out_valid_reg || out_ready;
  // Gating with rst_n keeps in_ready low for the whole reset period.
  assign load     = rst_n && gnt_valid && can_load;
  assign deliver  = out_valid_reg && out_ready;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*DATA_W +: DATA_W];
      assign in_ready[gi] = load && (gnt_idx == SEL_W'(gi));
    end
  endgenerate

  // The pointer only advances on a round-robin load; a fixed-mode load or a
  // mode change leaves it where it was.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (load && (mode == MODE_RR)) begin
      rr_ptr_next = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      rr_ptr_reg    <= '0;
      beat_cnt_reg  <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      if (deliver) begin
        beat_cnt_reg <= beat_cnt_reg + BEAT_CNT_W'(1);
      end
      if (load) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= ch_data[gnt_idx];
        out_ch_reg    <= gnt_idx;
      end else if (deliver) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign beat_cnt  = beat_cnt_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
// Directed and randomized checks of stream_mux_rr against a queue-free
// behavioural model of the output register, pointer and counter.
// A second instance with N_CH=6 covers the out-of-range select case.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  in_valid = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]  in_ready;
  logic [SW-1:0] sel = '0;
  logic          mode = MODE_FIXED;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_ch;
  logic          out_ready = 1'b0;
  logic [15:0]   beat_cnt;

  logic [5:0]    in_ready6;
  logic          out_valid6;
  logic [DW-1:0] out_data6;
  logic [SW-1:0] out_ch6;
  logic [15:0]   beat_cnt6;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready),
    .beat_cnt(beat_cnt)
  );

  stream_mux_rr #(.N_CH(6), .DATA_W(DW)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[5:0]), .in_data(in_data[6*DW-1:0]),
    .in_ready(in_ready6), .sel(sel), .mode(mode), .out_valid(out_valid6),
    .out_data(out_data6), .out_ch(out_ch6), .out_ready(out_ready),
    .beat_cnt(beat_cnt6)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int       m_ptr;
  bit       m_valid;
  logic [7:0] m_data;
  int       m_ch;
  int       m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = '0; m_ch = 0; m_cnt = 0;
  endtask

  // One clock cycle: predict the grant from the current inputs, check
  // in_ready before the edge, advance the model, check outputs after.
  task automatic cycle(input bit do_chk);
    bit g;
    int g_idx;
    bit load;
    logic [7:0] exp_ready;
    @(negedge clk);
    g = 0; g_idx = 0;
    if (mode == MODE_FIXED) begin
      if (int'(sel) < N && in_valid[sel]) begin g = 1; g_idx = int'(sel); end
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!g && in_valid[c]) begin g = 1; g_idx = c; end
      end
    end
    load = rst_n && g && (!m_valid || out_ready);
    exp_ready = load ? 8'(1 << g_idx) : 8'h00;
    if (do_chk) check("in_ready", in_ready, exp_ready);
    @(posedge clk);
    if (m_valid && out_ready) m_cnt = (m_cnt + 1) % 65536;
    if (load) begin
      m_valid = 1;
      m_data  = in_data[g_idx*8 +: 8];
      m_ch    = g_idx;
      if (mode == MODE_RR) m_ptr = (g_idx + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    #1;
    if (do_chk) begin
      check("out_valid", out_valid, m_valid);
      check("beat_cnt", beat_cnt, m_cnt);
      if (m_valid) begin
        check("out_data", out_data, m_data);
        check("out_ch", out_ch, m_ch);
      end
    end
    $display("cyc mode=%0d sel=%0d in_valid=%02h out_ready=%0d -> out_valid=%0d out_ch=%0d out_data=%02h beat_cnt=%0d",
             mode, sel, in_valid, out_ready, out_valid, out_ch, out_data, beat_cnt);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] frozen_d;
    logic [2:0] frozen_c;
    int rr_seq [6] = '{0, 2, 5, 7, 0, 2};

    // ---- Reset state, with traffic present on the inputs ----
    model_reset();
    in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_in_ready6", in_ready6, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- Fixed mode, sel stepped 0..7 ----
    mode = MODE_FIXED;
    for (int s = 0; s < N; s++) begin
      sel = 3'(s);
      cycle(1);
      check("fixed_data", out_data, 8'hA0 + 8'(s));
      check("fixed_ch", out_ch, s);
    end

    // ---- Round-robin from reset ----
    apply_reset();
    mode = MODE_RR; in_valid = 8'b1010_0101;
    for (int i = 0; i < 6; i++) begin
      cycle(1);
      check("rr_seq_ch", out_ch, rr_seq[i]);
    end
    in_valid = '0;
    cycle(1);
    check("rr_beat_cnt6", beat_cnt, 6);

    // ---- Backpressure ----
    in_valid = 8'hFF;
    cycle(1);
    frozen_d = out_data; frozen_c = out_ch;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1);
      check("bp_in_ready", in_ready, 0);
      check("bp_data_frozen", out_data, frozen_d);
      check("bp_ch_frozen", out_ch, frozen_c);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 8'(1 << ((int'(frozen_c) + 1) % N)));
    cycle(1);
    check("bp_next_ch", out_ch, (int'(frozen_c) + 1) % N);

    // ---- Invalid select on the 6-channel instance ----
    apply_reset();
    mode = MODE_FIXED; sel = 3'd7; in_valid = 8'hFF;
    #1;
    check("inv_sel_ready6", in_ready6, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1);
      check("inv_sel_ready6", in_ready6, 0);
      check("inv_sel_valid6", out_valid6, 0);
    end
    sel = 3'd5;
    #1;
    check("top_ch_ready6", in_ready6, 6'b10_0000);
    cycle(1);
    check("top_ch_out6", out_ch6, 5);
    check("top_ch_data6", out_data6, 8'hA5);

    // ---- Reset mid-stream ----
    mode = MODE_RR; in_valid = 8'hFF;
    cycle(1); cycle(1);
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_cnt", beat_cnt, 0);
    check("async_rst_ch", out_ch, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_ready", in_ready, 0);
    model_reset();
    @(posedge clk); #1;
    check("rst_hold_valid", out_valid, 0);
    rst_n = 1'b1;
    cycle(1);
    check("rr_restart_ch", out_ch, 0);

    // ---- Randomized traffic, including mode changes mid-stream ----
    for (int i = 0; i < 300; i++) begin
      in_valid  = 8'($urandom);
      in_data   = {$urandom, $urandom};
      sel       = 3'($urandom_range(0, 7));
      mode      = ($urandom_range(0, 3) == 0) ? MODE_FIXED : MODE_RR;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(1);
    end

    // ---- Counter wrap ----
    apply_reset();
    mode = MODE_FIXED; sel = 3'd0; in_valid = 8'h01; out_ready = 1'b1;
    while (m_cnt != 65535) begin
      @(negedge clk);
      @(posedge clk);
      if (m_valid) m_cnt = m_cnt + 1;
      m_valid = 1; m_ch = 0; m_data = in_data[7:0];
    end
    #1;
    check("cnt_pre_wrap", beat_cnt, 16'hFFFF);
    cycle(1);
    check("cnt_wrap", beat_cnt, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
